// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-like instruction and data ports onto one single-beat AXI3 master.
// One read FSM is shared by fetch and load; a separate write FSM handles stores.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_size_q, ar_size_d;
  logic        inst_ok_q, inst_ok_d;
  logic        rd_ok_q, rd_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [1:0]  aw_size_q, aw_size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        wr_ok_q, wr_ok_d;

  logic r_holds_data;
  logic data_rd_acc;
  logic data_wr_acc;
  logic inst_acc;

  // Fetch is read-only, so its write-side inputs carry nothing
  logic unused_inst_wr_side;
  assign unused_inst_wr_side = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

  // Data reads and writes exclude each other so the data port stays in order
  assign r_holds_data = (r_state_q != R_IDLE) && (ar_id_q == DATA_ID);
  assign data_rd_acc  = data_sram_req && !data_sram_wr && (r_state_q == R_IDLE) && (w_state_q == W_IDLE);
  assign data_wr_acc  = data_sram_req && data_sram_wr && (w_state_q == W_IDLE) && !r_holds_data;
  assign inst_acc     = inst_sram_req && (r_state_q == R_IDLE) && !data_rd_acc;

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = inst_ok_q;
  assign data_sram_data_ok = rd_ok_q || wr_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arvalid = (r_state_q == R_AR);
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign rready  = (r_state_q == R_R);

  assign awvalid = (w_state_q == W_REQ) && !aw_done_q;
  assign wvalid  = (w_state_q == W_REQ) && !w_done_q;
  assign bready  = (w_state_q == W_B);
  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, aw_size_q};
  assign wstrb   = wstrb_q;
  assign wdata   = wdata_q;

  always_comb begin
    r_state_d    = r_state_q;
    ar_id_d      = ar_id_q;
    ar_addr_d    = ar_addr_q;
    ar_size_d    = ar_size_q;
    inst_ok_d    = 1'b0;
    rd_ok_d      = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (data_rd_acc) begin
          ar_id_d   = DATA_ID;
          ar_addr_d = data_sram_addr;
          ar_size_d = data_sram_size;
          r_state_d = R_AR;
        end else if (inst_acc) begin
          ar_id_d   = INST_ID;
          ar_addr_d = inst_sram_addr;
          ar_size_d = inst_sram_size;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) r_state_d = R_R;
      end
      R_R: begin
        if (rvalid) begin
          if (rid == DATA_ID) begin
            rd_ok_d      = 1'b1;
            data_rdata_d = rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = rdata;
          end
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_size_d = aw_size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_ok_d   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (data_wr_acc) begin
          aw_addr_d = data_sram_addr;
          aw_size_d = data_sram_size;
          wstrb_d   = data_sram_wstrb;
          wdata_d   = data_sram_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W handshake independently; move on once both are done
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if ((aw_done_q || awready) && (w_done_q || wready)) w_state_d = W_B;
      end
      W_B: begin
        if (bvalid) begin
          wr_ok_d   = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q    <= R_IDLE;
      ar_id_q      <= 4'd0;
      ar_addr_q    <= 32'd0;
      ar_size_q    <= 2'd0;
      inst_ok_q    <= 1'b0;
      rd_ok_q      <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      w_state_q    <= W_IDLE;
      aw_addr_q    <= 32'd0;
      aw_size_q    <= 2'd0;
      wstrb_q      <= 4'd0;
      wdata_q      <= 32'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_ok_q      <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      ar_id_q      <= ar_id_d;
      ar_addr_q    <= ar_addr_d;
      ar_size_q    <= ar_size_d;
      inst_ok_q    <= inst_ok_d;
      rd_ok_q      <= rd_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      w_state_q    <= w_state_d;
      aw_addr_q    <= aw_addr_d;
      aw_size_q    <= aw_size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wr_ok_q      <= wr_ok_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Scenario bench for cpu_axi_bridge: tasks drive the AXI slave side by hand,
// a negedge monitor pops expected completions from per-port queues.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_inst_q[$];
  logic [32:0] exp_data_q[$];  // {is_write, rdata}

  cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Completion monitor: every data_ok must match the oldest expectation of its port
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_sram_data_ok) begin
        n_vec++;
        if (exp_inst_q.size() == 0) begin
          n_err++;
          $display("FAIL inst_stray_data_ok: got pulse, required none (rdata=%h)", inst_sram_rdata);
        end else begin
          logic [31:0] e;
          e = exp_inst_q.pop_front();
          if (inst_sram_rdata !== e) begin
            n_err++;
            $display("FAIL inst_rdata: got %h, required %h", inst_sram_rdata, e);
          end
        end
      end
      if (data_sram_data_ok) begin
        n_vec++;
        if (exp_data_q.size() == 0) begin
          n_err++;
          $display("FAIL data_stray_data_ok: got pulse, required none (rdata=%h)", data_sram_rdata);
        end else begin
          logic [32:0] e;
          e = exp_data_q.pop_front();
          if (!e[32] && data_sram_rdata !== e[31:0]) begin
            n_err++;
            $display("FAIL data_rdata: got %h, required %h", data_sram_rdata, e[31:0]);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  // Called at a negedge with arvalid up; returns at the negedge showing data_ok
  task automatic serve_read(input logic [3:0] id, input logic [31:0] d);
    arready = 1;
    @(negedge clk);
    arready = 0; rid = id; rdata = d; rvalid = 1;
    @(negedge clk);
    rvalid = 0;
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    n_vec++;
    if (exp_inst_q.size() != 0 || exp_data_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: pending inst=%0d data=%0d, required 0/0", name,
               exp_inst_q.size(), exp_data_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_valids: got %b, required 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    n_vec++;
    if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_oks: got %b, required 0000",
               {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    n_vec++;
    if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0 || araddr !== 32'd0 || awaddr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_regs: got irdata=%h drdata=%h araddr=%h awaddr=%h, required zeros",
               inst_sram_rdata, data_sram_rdata, araddr, awaddr);
    end
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_inst_fetch();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2'd2;
    #1;
    n_vec++;
    if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_addr_ok: got i=%b d=%b, required i=1 d=0", inst_sram_addr_ok, data_sram_addr_ok);
    end
    exp_inst_q.push_back(32'h3C08_0001);
    @(negedge clk);
    inst_sram_req = 0;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || arid !== 4'd0 || arsize !== 3'd2) begin
      n_err++;
      $display("FAIL fetch_ar: got v=%b addr=%h id=%h size=%h, required 1/bfc00000/0/2",
               arvalid, araddr, arid, arsize);
    end
    arready = 1;
    @(negedge clk);
    arready = 0;
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_rready: got arvalid=%b rready=%b, required 0/1", arvalid, rready);
    end
    @(negedge clk);
    rid = 4'd0; rdata = 32'h3C08_0001; rvalid = 1;
    @(negedge clk);
    rvalid = 0;
    n_vec++;
    if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_pulse: got i=%b d=%b, required i=1 d=0", inst_sram_data_ok, data_sram_data_ok);
    end
    @(negedge clk);
    n_vec++;
    if (inst_sram_data_ok !== 1'b0 || rready !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_pulse_width: got data_ok=%b rready=%b, required 0/0", inst_sram_data_ok, rready);
    end
    check_drained("fetch");
  endtask

  task automatic test_read_priority();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000; data_sram_size = 2'd2;
    #1;
    n_vec++;
    if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL prio_addr_ok: got d=%b i=%b, required d=1 i=0", data_sram_addr_ok, inst_sram_addr_ok);
    end
    exp_data_q.push_back({1'b0, 32'hA5A5_0001});
    @(negedge clk);
    data_sram_req = 0;
    #1;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_1000 || arid !== 4'd1 || inst_sram_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL prio_ar: got v=%b addr=%h id=%h iok=%b, required 1/00001000/1/0",
               arvalid, araddr, arid, inst_sram_addr_ok);
    end
    serve_read(4'd1, 32'hA5A5_0001);
    #1;
    n_vec++;
    if (inst_sram_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL prio_inst_after: got inst_addr_ok=%b, required 1", inst_sram_addr_ok);
    end
    exp_inst_q.push_back(32'h1111_2222);
    @(negedge clk);
    inst_sram_req = 0;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0004 || arid !== 4'd0) begin
      n_err++;
      $display("FAIL prio_inst_ar: got v=%b addr=%h id=%h, required 1/bfc00004/0", arvalid, araddr, arid);
    end
    serve_read(4'd0, 32'h1111_2222);
    check_drained("prio");
  endtask

  task automatic test_store();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1FC0_0010; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF;
    #1;
    n_vec++;
    if (data_sram_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL store_addr_ok: got %b, required 1", data_sram_addr_ok);
    end
    exp_data_q.push_back({1'b1, 32'd0});
    @(negedge clk);
    data_sram_req = 0;
    n_vec++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h1FC0_0010 || awsize !== 3'd2 ||
        awid !== 4'd1 || wid !== 4'd1 || wstrb !== 4'hF || wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL store_aw_w: got av=%b wv=%b addr=%h size=%h awid=%h wid=%h strb=%h data=%h, required 1/1/1fc00010/2/1/1/f/deadbeef",
               awvalid, wvalid, awaddr, awsize, awid, wid, wstrb, wdata);
    end
    awready = 1;
    @(negedge clk);
    awready = 0;
    n_vec++;
    if (awvalid !== 1'b0 || wvalid !== 1'b1) begin
      n_err++;
      $display("FAIL store_aw_first: got awvalid=%b wvalid=%b, required 0/1", awvalid, wvalid);
    end
    wready = 1;
    @(negedge clk);
    wready = 0;
    n_vec++;
    if (wvalid !== 1'b0 || bready !== 1'b1 || data_sram_data_ok !== 1'b0) begin
      n_err++;
      $display("FAIL store_b: got wvalid=%b bready=%b data_ok=%b, required 0/1/0", wvalid, bready, data_sram_data_ok);
    end
    bvalid = 1;
    @(negedge clk);
    bvalid = 0;
    n_vec++;
    if (data_sram_data_ok !== 1'b1 || bready !== 1'b0) begin
      n_err++;
      $display("FAIL store_done: got data_ok=%b bready=%b, required 1/0", data_sram_data_ok, bready);
    end
    check_drained("store");
  endtask

  task automatic test_raw_block();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_2001; data_sram_size = 2'd1;
    data_sram_wstrb = 4'b0110; data_sram_wdata = 32'h1234_5678;
    exp_data_q.push_back({1'b1, 32'd0});
    @(negedge clk);
    data_sram_wr = 0;
    #1;
    n_vec++;
    if (data_sram_addr_ok !== 1'b0 || awaddr !== 32'h0000_2001 || awsize !== 3'd1 ||
        wstrb !== 4'b0110 || wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL raw_wreq: got aok=%b addr=%h size=%h strb=%h data=%h, required 0/00002001/1/6/12345678",
               data_sram_addr_ok, awaddr, awsize, wstrb, wdata);
    end
    awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    #1;
    n_vec++;
    if (data_sram_addr_ok !== 1'b0 || arvalid !== 1'b0 || bready !== 1'b1) begin
      n_err++;
      $display("FAIL raw_wb: got aok=%b arvalid=%b bready=%b, required 0/0/1", data_sram_addr_ok, arvalid, bready);
    end
    bvalid = 1;
    @(negedge clk);
    bvalid = 0;
    #1;
    n_vec++;
    if (data_sram_addr_ok !== 1'b1 || data_sram_data_ok !== 1'b1) begin
      n_err++;
      $display("FAIL raw_release: got aok=%b data_ok=%b, required 1/1", data_sram_addr_ok, data_sram_data_ok);
    end
    exp_data_q.push_back({1'b0, 32'h0BAD_F00D});
    @(negedge clk);
    data_sram_req = 0;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_2001 || arid !== 4'd1 || arsize !== 3'd1) begin
      n_err++;
      $display("FAIL raw_load_ar: got v=%b addr=%h id=%h size=%h, required 1/00002001/1/1",
               arvalid, araddr, arid, arsize);
    end
    serve_read(4'd1, 32'h0BAD_F00D);
    check_drained("raw");
  endtask

  task automatic test_ar_stall();
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_3002; data_sram_size = 2'd1;
    exp_data_q.push_back({1'b0, 32'h0000_00EE});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0040;
      data_sram_addr = 32'h0000_3100 + 32'(i);
      #1;
      n_vec++;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_3002 || arsize !== 3'd1 ||
          inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%b addr=%h size=%h iok=%b dok=%b, required 1/00003002/1/0/0",
                 i, arvalid, araddr, arsize, inst_sram_addr_ok, data_sram_addr_ok);
      end
    end
    inst_sram_req = 0; data_sram_req = 0;
    serve_read(4'd1, 32'h0000_00EE);
    check_drained("stall");
  endtask

  task automatic test_dual_complete();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0080;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_5000;
    data_sram_wstrb = 4'h3; data_sram_wdata = 32'hCAFE_0000;
    #1;
    n_vec++;
    if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL dual_accept: got i=%b d=%b, required 1/1", inst_sram_addr_ok, data_sram_addr_ok);
    end
    exp_inst_q.push_back(32'h7777_0007);
    exp_data_q.push_back({1'b1, 32'd0});
    @(negedge clk);
    inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
    arready = 1; awready = 1; wready = 1;
    @(negedge clk);
    arready = 0; awready = 0; wready = 0;
    rid = 4'd0; rdata = 32'h7777_0007; rvalid = 1; bvalid = 1;
    @(negedge clk);
    rvalid = 0; bvalid = 0;
    n_vec++;
    if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b1) begin
      n_err++;
      $display("FAIL dual_pulse: got i=%b d=%b, required 1/1", inst_sram_data_ok, data_sram_data_ok);
    end
    check_drained("dual");
  endtask

  task automatic test_reset_midflight();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0020;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_4000;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'h5555_AAAA;
    @(negedge clk);
    inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
    arready = 1;
    @(negedge clk);
    arready = 0;
    n_vec++;
    if (rready !== 1'b1 || awvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got rready=%b awvalid=%b, required 1/1", rready, awvalid);
    end
    resetn = 0;
    #1;
    n_vec++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_async: got %b, required 00000", {arvalid, rready, awvalid, wvalid, bready});
    end
    @(negedge clk);
    resetn = 1;
    rid = 4'd0; rdata = 32'h0000_0BAD; rvalid = 1; bvalid = 1;
    @(negedge clk);
    rvalid = 0; bvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'd0) begin
        n_err++;
        $display("FAIL rst_stray_%0d: got i=%b d=%b irdata=%h, required 0/0/00000000",
                 i, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_read_priority();
    test_store();
    test_raw_block();
    test_ar_stall();
    test_dual_complete();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the core's two SRAM-like master ports (inst_sram_*, data_sram_*) into one AXI3-style master with single-beat transfers. It sits directly downstream of the CPU top and consumes its inst/data request handshakes. It arbitrates reads between fetch and load/store, and returns data_ok/rdata to the originating port. AXI constant fields (len=0, burst=INCR, lock/cache/prot=0, wlast=1) are tied off in the SoC wrapper and are not ports here.

Parameters:
INST_ID, 4'd0, arid/rid tag for instruction reads
DATA_ID, 4'd1, arid/rid/awid tag for data accesses

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
inst_sram_req / data_sram_req  in  1  request valid from core
inst_sram_wr / data_sram_wr  in  1  1=write; inst_sram_wr ignored (fetch is read-only)
inst_sram_size / data_sram_size  in  2  0=byte, 1=half, 2=word
inst_sram_addr / data_sram_addr  in  32  byte address
inst_sram_wstrb / data_sram_wstrb  in  4  byte enables (data only used)
inst_sram_wdata / data_sram_wdata  in  32  write data (data only used)
inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok / data_sram_data_ok  out  1  one-cycle pulse: read data valid or write done
inst_sram_rdata / data_sram_rdata  out  32  read data, valid with data_ok
arid, araddr, arsize, arvalid  out  4/32/3/1  AR channel
arready  in  1  AR accept
rid, rdata, rvalid  in  4/32/1  R channel
rready  out  1  R accept
awid, awaddr, awsize, awvalid  out  4/32/3/1  AW channel
awready  in  1  AW accept
wid, wdata, wstrb, wvalid  out  4/32/4/1  W channel
wready  in  1  W accept
bvalid  in  1  B response valid
bready  out  1  B accept

Behaviour:
- Reset (resetn=0, async): read FSM=R_IDLE, write FSM=W_IDLE; arvalid/awvalid/wvalid/rready/bready=0; addr_ok/data_ok=0; rdata outputs=0; latched addr/size/strb/data cleared. Reset mid-transaction abandons it; no data_ok is issued afterwards.
- Outstanding limit: at most one inst read and one data access (read or write) in flight in total through the bridge. Data port is strictly in-order by construction.
- addr_ok is combinational from req and FSM state; a request is accepted on a cycle with req&addr_ok. Address/size/wstrb/wdata are latched on acceptance.
- Read FSM: R_IDLE -> R_AR -> R_R -> R_IDLE.
  - R_IDLE: accepts a data read (data_sram_req & !data_sram_wr & write FSM==W_IDLE) with priority; otherwise accepts an inst read (inst_sram_req). Only one addr_ok is asserted per cycle. The cycle after acceptance, arvalid=1, arid=tag, arsize={1'b0,size}.
  - R_AR: arvalid is held with stable fields until arready. Then rready=1 from the next cycle.
  - R_R: on rvalid, route by rid (DATA_ID -> data port, else inst port). Pulse that port's data_ok for one cycle with rdata registered, then return to R_IDLE. Earliest next acceptance is the same cycle as the data_ok pulse.
- Write FSM: W_IDLE -> W_REQ -> W_B -> W_IDLE.
  - W_IDLE: accepts data_sram_req & data_sram_wr only when the read FSM holds no data read. A data read and a data write are never accepted in the same cycle (read wins).
  - W_REQ: awvalid and wvalid are both asserted. Each deasserts independently after its own ready. Leave W_REQ when both have handshaken, in either order or the same cycle.
  - W_B: bready=1. On bvalid, pulse data_sram_data_ok for one cycle, then go to W_IDLE.
- awsize={1'b0,size}; wstrb is passed through unmodified; awaddr is passed unaligned; awid=wid=DATA_ID.
- A data read is blocked while any write is in W_REQ/W_B, which removes the read-after-write hazard.
- Simultaneous inst rvalid-completion and write bvalid are legal; both data_ok pulses occur in the same cycle on different ports.

Test Plan:
1. Inst fetch: inst req addr=0xBFC00000, arready=1 next cycle, rvalid with rid=0 and rdata=0x3C080001 two cycles later -> one inst_sram_data_ok pulse, inst_sram_rdata=0x3C080001, data_sram_data_ok stays 0.
2. Simultaneous inst and data read in R_IDLE -> data_sram_addr_ok=1, inst_sram_addr_ok=0; araddr=data addr, arid=1. Inst is accepted only after the data read completes.
3. Word store 0x1FC0_0010, wstrb=4'hF, wdata=0xDEADBEEF; awready one cycle before wready -> awvalid drops first, wvalid held; one data_data_ok pulse after bvalid.
4. Store in flight, then load to same addr -> data_sram_addr_ok=0 until the write's data_ok pulse; the load is then accepted and arvalid rises.
5. arready held low 5 cycles -> arvalid, araddr and arsize stable for all 5 cycles; no second addr_ok in the meantime.
6. resetn pulled low while in R_R -> all valids/readies drop immediately; after release, no stray data_ok even if a late rvalid arrives.
